// File: rtl/pmem_prefetch_arbiter.sv
// Purpose: arbitrates the single pmem port between L2 demand traffic and prefetch-buffer fills.
// Latency: buffer hit answers one cycle after the request; a pmem transaction answers in the pmem_resp cycle.
// Backpressure: L2 holds its request until l2_resp; wait_l2 flags a stall behind a non-abortable prefetch.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   l2_read/l2_write        L2 demand requests, held until l2_resp (write wins if both are set)
//   l2_address, l2_wdata    L2 request address and write-back data
//   l2_rdata, l2_resp       read data and one-cycle completion pulse back to L2
//   wait_l2                 L2 request present while a prefetch owns pmem
//   pf_req, pf_address      one-cycle prefetch request; a newer request replaces a pending one
//   buf_address             lookup/fill address for the prefetch buffer
//   buf_hit, buf_rdata      buffer lookup result for buf_address (combinational in the buffer)
//   buf_fill                write pmem_rdata into the buffer line at buf_address
//   buf_invalidate          clear the buffer line at buf_address
//   pmem_*                  physical memory strobes, address, data and completion pulse
//   pf_issued_cnt           completed prefetch fills, saturating
//   pf_hit_cnt              L2 reads served from the buffer, saturating
module pmem_prefetch_arbiter #(
  parameter int BLOCK_W     = 128,
  parameter int OFFSET_BITS = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l2_read,
  input  logic               l2_write,
  input  logic [15:0]        l2_address,
  input  logic [BLOCK_W-1:0] l2_wdata,
  output logic [BLOCK_W-1:0] l2_rdata,
  output logic               l2_resp,
  output logic               wait_l2,
  input  logic               pf_req,
  input  logic [15:0]        pf_address,
  output logic [15:0]        buf_address,
  input  logic               buf_hit,
  input  logic [BLOCK_W-1:0] buf_rdata,
  output logic               buf_fill,
  output logic               buf_invalidate,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [15:0]        pmem_address,
  output logic [BLOCK_W-1:0] pmem_wdata,
  input  logic [BLOCK_W-1:0] pmem_rdata,
  input  logic               pmem_resp,
  output logic [CNT_W-1:0]   pf_issued_cnt,
  output logic [CNT_W-1:0]   pf_hit_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HIT_RESP = 3'd1,
    DEM_RD   = 3'd2,
    DEM_WR   = 3'd3,
    PF_RD    = 3'd4
  } state_t;

  state_t             state;
  logic               pf_pending;
  logic               pf_stale;
  logic [15:0]        pf_addr_q;
  logic [15:0]        pf_issue_q;
  logic [BLOCK_W-1:0] hit_data_q;
  logic [CNT_W-1:0]   issued_q;
  logic [CNT_W-1:0]   hit_q;

  logic l2_req;
  logic l2_rd_eff;
  logic pf_same_blk;
  logic stale_now;
  logic fill_now;
  logic pend_clr;

  function automatic logic same_block(input logic [15:0] a, input logic [15:0] b);
    return a[15:OFFSET_BITS] == b[15:OFFSET_BITS];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Write wins when L2 (illegally) raises both requests.
  assign l2_req    = l2_read | l2_write;
  assign l2_rd_eff = l2_read & ~l2_write;

  assign pf_same_blk = same_block(l2_address, pf_addr_q);

  // A write-back to the block being prefetched makes the in-flight data stale;
  // it must also catch a write that shows up in the very cycle pmem answers.
  assign stale_now = (state == PF_RD) && l2_write && same_block(l2_address, pf_issue_q);
  assign fill_now  = (state == PF_RD) && pmem_resp && !(pf_stale || stale_now);

  // Pending prefetch leaves the register either by issuing or by being
  // superseded by a demand read of the same block (that read goes to pmem anyway).
  always_comb begin
    pend_clr = 1'b0;
    if (state == IDLE && !l2_write && pf_pending) begin
      if (l2_read && !buf_hit)
        pend_clr = pf_same_blk;
      else if (!l2_read)
        pend_clr = 1'b1;
    end
  end

  // Buffer lookup follows L2 whenever L2 can be served; a prefetch in flight
  // keeps the fill address on the bus so buf_fill lands on the right line.
  always_comb begin
    buf_address = pf_addr_q;
    if (state == PF_RD)
      buf_address = pf_issue_q;
    else if (l2_req)
      buf_address = l2_address;
  end

  // Strobes decode straight off the state flop, so an asynchronous reset
  // drops them in the same instant it forces IDLE.
  always_comb begin
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pmem_address   = 16'h0000;
    pmem_wdata     = '0;
    l2_resp        = 1'b0;
    l2_rdata       = '0;
    wait_l2        = 1'b0;
    buf_fill       = 1'b0;
    buf_invalidate = 1'b0;
    case (state)
      IDLE: begin
        buf_invalidate = l2_write & buf_hit;
      end
      HIT_RESP: begin
        l2_resp  = 1'b1;
        l2_rdata = hit_data_q;
      end
      DEM_RD: begin
        pmem_read    = 1'b1;
        pmem_address = l2_address;
        l2_resp      = pmem_resp;
        if (pmem_resp)
          l2_rdata = pmem_rdata;
      end
      DEM_WR: begin
        pmem_write   = 1'b1;
        pmem_address = l2_address;
        pmem_wdata   = l2_wdata;
        l2_resp      = pmem_resp;
      end
      PF_RD: begin
        pmem_read    = 1'b1;
        pmem_address = pf_issue_q;
        wait_l2      = l2_req;
        buf_fill     = fill_now;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pf_pending <= 1'b0;
      pf_stale   <= 1'b0;
      pf_addr_q  <= 16'h0000;
      pf_issue_q <= 16'h0000;
      hit_data_q <= '0;
      issued_q   <= '0;
      hit_q      <= '0;
    end else begin
      // A fresh request always lands, even in the cycle the old one issues.
      if (pf_req) begin
        pf_pending <= 1'b1;
        pf_addr_q  <= pf_address;
      end else if (pend_clr) begin
        pf_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (l2_write) begin
            state <= DEM_WR;
          end else if (l2_rd_eff && buf_hit) begin
            state      <= HIT_RESP;
            hit_data_q <= buf_rdata;
          end else if (l2_rd_eff) begin
            state <= DEM_RD;
          end else if (pf_pending) begin
            state      <= PF_RD;
            pf_issue_q <= pf_addr_q;
          end
        end
        HIT_RESP: begin
          hit_q <= sat_inc(hit_q);
          state <= IDLE;
        end
        DEM_RD, DEM_WR: begin
          if (pmem_resp)
            state <= IDLE;
        end
        PF_RD: begin
          if (pmem_resp) begin
            pf_stale <= 1'b0;
            if (fill_now)
              issued_q <= sat_inc(issued_q);
            state <= IDLE;
          end else if (stale_now) begin
            pf_stale <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pf_issued_cnt = issued_q;
  assign pf_hit_cnt    = hit_q;

  a_pmem_excl: assert property (@(posedge clk) disable iff (reset) !(pmem_read && pmem_write));
  a_resp_idle: assert property (@(posedge clk) disable iff (reset) l2_resp |=> state == IDLE);

endmodule

// File: tb/tb_pmem_prefetch_arbiter.sv
module tb_pmem_prefetch_arbiter;
  localparam int BW = 128;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          l2_read, l2_write;
  logic [15:0]   l2_address;
  logic [BW-1:0] l2_wdata;
  logic [BW-1:0] l2_rdata;
  logic          l2_resp, wait_l2;
  logic          pf_req;
  logic [15:0]   pf_address;
  logic [15:0]   buf_address;
  logic          buf_hit;
  logic [BW-1:0] buf_rdata;
  logic          buf_fill, buf_invalidate;
  logic          pmem_read, pmem_write;
  logic [15:0]   pmem_address;
  logic [BW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  logic [CW-1:0] pf_issued_cnt, pf_hit_cnt;

  always #5 clk = ~clk;

  pmem_prefetch_arbiter #(.BLOCK_W(BW), .OFFSET_BITS(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp), .wait_l2(wait_l2),
    .pf_req(pf_req), .pf_address(pf_address),
    .buf_address(buf_address), .buf_hit(buf_hit), .buf_rdata(buf_rdata),
    .buf_fill(buf_fill), .buf_invalidate(buf_invalidate),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .pf_issued_cnt(pf_issued_cnt), .pf_hit_cnt(pf_hit_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mem_fn(input logic [15:0] a);
    return {4{a, ~a}};
  endfunction

  function automatic int sat(input int n);
    int m;
    m = (1 << CW) - 1;
    return (n > m) ? m : n;
  endfunction

  // pmem model: answers after pm_lat strobe cycles, or follows pm_force when disabled.
  int pm_lat  = 2;
  bit pm_auto = 1'b1;
  bit pm_force = 1'b0;
  int pm_cnt  = 0;

  always @(posedge clk) begin
    #1;
    if (!pm_auto) begin
      pmem_resp = pm_force;
    end else if (!reset && (pmem_read || pmem_write) && !pmem_resp) begin
      pm_cnt++;
      if (pm_cnt >= pm_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_fn(pmem_address);
        pm_cnt     = 0;
      end
    end else begin
      pmem_resp = 1'b0;
      pm_cnt    = 0;
    end
  end

  // Scoreboards: expected pmem transactions and expected L2 read data.
  typedef struct {
    bit            wr;
    logic [15:0]   addr;
    logic [BW-1:0] wdata;
  } pm_exp_t;

  pm_exp_t       pm_q[$];
  logic [BW-1:0] l2_q[$];

  task automatic pm_push(input bit wr, input logic [15:0] addr, input logic [BW-1:0] wd);
    pm_exp_t e;
    e.wr = wr; e.addr = addr; e.wdata = wd;
    pm_q.push_back(e);
  endtask

  logic        prev_strobe = 1'b0;
  logic        prev_resp   = 1'b0;
  int          fill_cnt = 0;
  int          inval_cnt = 0;
  int          wait_cnt = 0;
  logic [15:0] last_fill_addr = '0;

  always @(negedge clk) begin
    pm_exp_t       e;
    logic [BW-1:0] d;
    if (reset) begin
      prev_strobe = 1'b0;
      prev_resp   = 1'b0;
    end else begin
      check("pmem_excl", pmem_read & pmem_write, 0);
      check("pmem_hold", prev_strobe & ~prev_resp & ~(pmem_read | pmem_write), 0);
      if ((pmem_read || pmem_write) && !prev_strobe) begin
        check("pmem_txn_expected", pm_q.size() != 0, 1);
        if (pm_q.size() != 0) begin
          e = pm_q.pop_front();
          check("pmem_address", pmem_address, e.addr);
          check("pmem_kind", pmem_write, e.wr);
          if (e.wr) check("pmem_wdata", pmem_wdata, e.wdata);
        end
      end
      if (l2_resp) begin
        check("l2_resp_expected", l2_q.size() != 0, 1);
        if (l2_q.size() != 0) begin
          d = l2_q.pop_front();
          check("l2_rdata", l2_rdata, d);
        end
      end
      if (buf_fill) begin
        fill_cnt++;
        last_fill_addr = buf_address;
      end
      if (buf_invalidate) inval_cnt++;
      if (wait_l2) wait_cnt++;
      prev_strobe = pmem_read | pmem_write;
      prev_resp   = pmem_resp;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one L2 request, hold it until l2_resp, drop it the next cycle.
  // lat = number of sampled cycles up to and including the l2_resp cycle (0 = timeout).
  task automatic l2_txn(input bit wr, input logic [15:0] addr, input logic [BW-1:0] wd,
                        input bit hit, input logic [BW-1:0] bd, output int lat);
    l2_write = wr; l2_read = !wr; l2_address = addr; l2_wdata = wd;
    buf_hit = hit; buf_rdata = bd;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (l2_resp) begin
        lat = k;
        break;
      end
    end
    step();
    l2_read = 1'b0; l2_write = 1'b0; buf_hit = 1'b0;
  endtask

  task automatic wait_fill(input int f0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (fill_cnt != f0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pmem_read) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    bit            wr;
    logic [15:0]   addr;
    bit            hit;
    logic [BW-1:0] wdata;
    logic [BW-1:0] bdata;
    int            exp_lat;
    int            exp_inv;
  } vec_t;

  function automatic vec_t mk(input bit wr, input logic [15:0] addr, input bit hit,
                              input logic [BW-1:0] wd, input logic [BW-1:0] bd,
                              input int lat, input int inv);
    vec_t v;
    v.wr = wr; v.addr = addr; v.hit = hit; v.wdata = wd; v.bdata = bd;
    v.exp_lat = lat; v.exp_inv = inv;
    return v;
  endfunction

  vec_t vt[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, inv0, f0, w0, hits, n_fills;
    bit  ok;

    vt[0] = mk(0, 16'h1234, 1, '0, {4{32'hB0B0_1234}}, 2, 0);
    vt[1] = mk(0, 16'h4000, 0, '0, '0, 3, 0);
    vt[2] = mk(1, 16'h5010, 1, {4{32'hC0DE_5010}}, '0, 3, 1);
    vt[3] = mk(1, 16'h6020, 0, {4{32'h1111_6020}}, '0, 3, 0);
    vt[4] = mk(0, 16'hFFF0, 1, '1, {4{32'hFFFF_0000}}, 2, 0);
    vt[5] = mk(0, 16'h0000, 0, '0, '0, 3, 0);
    vt[6] = mk(0, 16'h0ABC, 1, '0, {4{32'h0ABC_0ABC}}, 2, 0);
    vt[7] = mk(0, 16'h7FFF, 1, '0, {4{32'h7777_8888}}, 2, 0);

    reset = 1'b1;
    l2_read = 1'b0; l2_write = 1'b0; l2_address = '0; l2_wdata = '0;
    pf_req = 1'b0; pf_address = '0; buf_hit = 1'b0; buf_rdata = '0;
    hits = 0; n_fills = 0;

    step(); step();
    @(negedge clk);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_l2_resp", l2_resp, 0);
    check("rst_wait_l2", wait_l2, 0);
    check("rst_buf_strobes", {buf_fill, buf_invalidate}, 0);
    check("rst_counters", {pf_issued_cnt, pf_hit_cnt}, 0);
    check("rst_data", l2_rdata | pmem_wdata, 0);
    check("rst_pmem_address", pmem_address, 0);
    step();
    reset = 1'b0;
    step();

    // Table: standalone L2 transactions with an idle prefetcher.
    pm_lat = 2;
    for (int i = 0; i < 8; i++) begin
      if (vt[i].hit && !vt[i].wr) begin
        hits++;
        l2_q.push_back(vt[i].bdata);
      end else begin
        pm_push(vt[i].wr, vt[i].addr, vt[i].wdata);
        l2_q.push_back(vt[i].wr ? {BW{1'b0}} : mem_fn(vt[i].addr));
      end
      inv0 = inval_cnt;
      l2_txn(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].hit, vt[i].bdata, lat);
      check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      check($sformatf("v%0d_invalidate", i), inval_cnt - inv0, vt[i].exp_inv);
      @(negedge clk);
      check($sformatf("v%0d_resp_pulse", i), l2_resp, 0);
      check($sformatf("v%0d_hit_cnt", i), pf_hit_cnt, sat(hits));
      step();
    end

    // A: lone prefetch, slow pmem.
    pm_lat = 5; f0 = fill_cnt;
    pm_push(0, 16'h1230, '0);
    pf_address = 16'h1230; pf_req = 1'b1; step(); pf_req = 1'b0;
    wait_fill(f0, ok);
    check("A_fill_seen", ok, 1);
    check("A_fill_addr", last_fill_addr, 16'h1230);
    n_fills++;
    step(); step();
    @(negedge clk); #1;
    check("A_fill_once", fill_cnt - f0, 1);
    check("A_issued", pf_issued_cnt, sat(n_fills));
    step();

    // B: L2 read stalls behind an in-flight prefetch.
    pm_lat = 4; f0 = fill_cnt; w0 = wait_cnt;
    pm_push(0, 16'h7000, '0);
    pf_address = 16'h7000; pf_req = 1'b1; step(); pf_req = 1'b0;
    wait_strobe(ok);
    check("B_pf_start", ok, 1);
    step();
    pm_push(0, 16'h4000, '0);
    l2_q.push_back(mem_fn(16'h4000));
    l2_txn(0, 16'h4000, '0, 0, '0, lat);
    check("B_latency", lat, 8);
    check("B_wait_cycles", wait_cnt - w0, 3);
    check("B_fill", fill_cnt - f0, 1);
    check("B_fill_addr", last_fill_addr, 16'h7000);
    n_fills++;
    @(negedge clk);
    check("B_issued", pf_issued_cnt, sat(n_fills));
    step();

    // C: write-back to the prefetched block mid-flight suppresses the fill.
    pm_lat = 4; f0 = fill_cnt;
    pm_push(0, 16'h1230, '0);
    pf_address = 16'h1230; pf_req = 1'b1; step(); pf_req = 1'b0;
    wait_strobe(ok);
    check("C_pf_start", ok, 1);
    step();
    pm_push(1, 16'h1238, {4{32'h5757_1238}});
    l2_q.push_back({BW{1'b0}});
    l2_txn(1, 16'h1238, {4{32'h5757_1238}}, 0, '0, lat);
    check("C_latency", lat, 8);
    check("C_no_fill", fill_cnt - f0, 0);
    @(negedge clk);
    check("C_issued", pf_issued_cnt, sat(n_fills));
    step();

    // C2: same-block write arrives in the exact pmem_resp cycle.
    pm_lat = 2; f0 = fill_cnt;
    pm_push(0, 16'h5550, '0);
    pf_address = 16'h5550; pf_req = 1'b1; step(); pf_req = 1'b0;
    wait_strobe(ok);
    check("C2_pf_start", ok, 1);
    step();
    pm_push(1, 16'h555C, {4{32'h0F0F_555C}});
    l2_q.push_back({BW{1'b0}});
    l2_txn(1, 16'h555C, {4{32'h0F0F_555C}}, 0, '0, lat);
    check("C2_latency", lat, 4);
    check("C2_no_fill", fill_cnt - f0, 0);
    step();

    // D: two prefetch pulses during a demand read; only the latest is fetched.
    pm_lat = 4; f0 = fill_cnt;
    pm_push(0, 16'h8000, '0);
    l2_q.push_back(mem_fn(16'h8000));
    pm_push(0, 16'h3000, '0);
    fork
      l2_txn(0, 16'h8000, '0, 0, '0, lat);
      begin
        step(); pf_address = 16'h2000; pf_req = 1'b1;
        step(); pf_address = 16'h3000;
        step(); pf_req = 1'b0;
      end
    join
    check("D_latency", lat, 5);
    wait_fill(f0, ok);
    check("D_fill_seen", ok, 1);
    check("D_fill_addr", last_fill_addr, 16'h3000);
    n_fills++;
    step();
    @(negedge clk);
    check("D_issued", pf_issued_cnt, sat(n_fills));
    step();

    // E: demand read and pending prefetch together in IDLE; demand first.
    f0 = fill_cnt;
    pm_push(0, 16'hA000, '0);
    l2_q.push_back(mem_fn(16'hA000));
    pm_push(0, 16'h9000, '0);
    pf_address = 16'h9000; pf_req = 1'b1; step(); pf_req = 1'b0;
    l2_txn(0, 16'hA000, '0, 0, '0, lat);
    check("E_latency", lat, 5);
    wait_fill(f0, ok);
    check("E_fill_seen", ok, 1);
    check("E_fill_addr", last_fill_addr, 16'h9000);
    n_fills++;
    step();
    @(negedge clk);
    check("E_issued_saturated", pf_issued_cnt, sat(n_fills));
    step();

    // F: demand miss to the pending prefetch's block drops the prefetch.
    pm_lat = 2; f0 = fill_cnt;
    pm_push(0, 16'hB004, '0);
    l2_q.push_back(mem_fn(16'hB004));
    pf_address = 16'hB000; pf_req = 1'b1; step(); pf_req = 1'b0;
    l2_txn(0, 16'hB004, '0, 0, '0, lat);
    check("F_latency", lat, 3);
    for (int k = 0; k < 8; k++) step();
    @(negedge clk);
    check("F_no_fill", fill_cnt - f0, 0);
    check("F_pmem_idle", pmem_read, 0);
    step();

    // G: asynchronous reset in the middle of a demand read.
    pm_auto = 1'b0;
    pm_push(0, 16'hC000, '0);
    l2_read = 1'b1; l2_address = 16'hC000; buf_hit = 1'b0;
    wait_strobe(ok);
    check("G_rd_start", ok, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("G_rst_pmem_read", pmem_read, 0);
    check("G_rst_strobes", {pmem_write, l2_resp, wait_l2, buf_fill}, 0);
    check("G_rst_counters", {pf_issued_cnt, pf_hit_cnt}, 0);
    step();
    reset = 1'b0; l2_read = 1'b0;
    @(negedge clk);
    pm_force = 1'b1;
    @(negedge clk);
    check("G_late_resp_ignored", {l2_resp, buf_fill}, 0);
    pm_force = 1'b0;
    @(negedge clk);
    check("G_idle_after", {pmem_read, pmem_write}, 0);
    check("G_idle_address", pmem_address, 0);

    check("pm_queue_drained", pm_q.size(), 0);
    check("l2_queue_drained", l2_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmem_prefetch_arbiter.md
Name: pmem_prefetch_arbiter

Overview:
Sequences the single physical-memory port between L2 demand traffic (reads and write-backs) and instruction-stream prefetch fills into the prefetch buffer.
Serves L2 reads that hit the prefetch buffer without touching pmem, and drives the buffer's fill and invalidate strobes.
Sits between the L2 cache's pmem side, the prefetch buffer arrays and physical memory, and replaces the ad-hoc mux/response steering around the buffer.

Parameters:
BLOCK_W, 128, cache block width in bits (pmem/L2 data width)
OFFSET_BITS, 4, byte-offset bits within a block; block compare uses address[15:OFFSET_BITS]
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
l2_read  in  1  L2 demand read request, held until l2_resp
l2_write  in  1  L2 write-back request, held until l2_resp
l2_address  in  16  L2 request address
l2_wdata  in  BLOCK_W  write-back data
l2_rdata  out  BLOCK_W  read data returned to L2
l2_resp  out  1  one-cycle completion pulse to L2
wait_l2  out  1  high while an L2 request is stalled behind an in-flight prefetch
pf_req  in  1  one-cycle prefetch request pulse
pf_address  in  16  prefetch target address
buf_address  out  16  lookup/fill address to prefetch buffer
buf_hit  in  1  combinational valid&tag match for buf_address
buf_rdata  in  BLOCK_W  buffer data at buf_address
buf_fill  out  1  write pmem_rdata/tag into buffer, set valid
buf_invalidate  out  1  clear valid of the line at buf_address
pmem_read  out  1  physical memory read strobe
pmem_write  out  1  physical memory write strobe
pmem_address  out  16  physical memory address
pmem_wdata  out  BLOCK_W  physical memory write data
pmem_rdata  in  BLOCK_W  physical memory read data
pmem_resp  in  1  physical memory completion pulse
pf_issued_cnt  out  CNT_W  prefetch fills completed, saturating
pf_hit_cnt  out  CNT_W  L2 reads served from the buffer, saturating

Behaviour:
- Reset (async): state IDLE; pf_pending=0; pf_stale=0; counters=0. All strobes (pmem_read/write, l2_resp, buf_fill, buf_invalidate, wait_l2) are 0 immediately, including when reset is asserted mid-transaction. Data outputs are 0.
- Pending prefetch register: pf_req sets pf_pending and loads pf_addr_q; a newer pf_req overwrites the older one (latest wins). pf_req in the same cycle as issue has priority and stays pending.
- States: IDLE, HIT_RESP, DEM_RD, DEM_WR, PF_RD.
- buf_address = l2_address when the state is IDLE/HIT_RESP/DEM_* and an L2 request is present; otherwise it is the prefetch address (pf_addr_q in IDLE, pf_issue_q in PF_RD).
- IDLE, priority demand > prefetch:
  - l2_read & buf_hit -> HIT_RESP; register buf_rdata.
  - l2_read & !buf_hit -> DEM_RD. A pending prefetch to the same block (address[15:OFFSET_BITS] equal) is dropped.
  - l2_write -> DEM_WR; buf_invalidate=1 this cycle if buf_hit.
  - Otherwise pf_pending -> PF_RD; latch pf_issue_q=pf_addr_q; clear pf_pending.
  - l2_read and l2_write are never both asserted; if they are, write wins.
- HIT_RESP: l2_resp=1; l2_rdata=registered buffer data; pf_hit_cnt++; -> IDLE.
- DEM_RD: pmem_read=1, pmem_address=l2_address. On pmem_resp: l2_resp=1 in that cycle, l2_rdata=pmem_rdata, -> IDLE. A demand read does not fill the buffer.
- DEM_WR: pmem_write=1, address/wdata from L2. On pmem_resp: l2_resp=1 -> IDLE.
- PF_RD: pmem_read=1, pmem_address=pf_issue_q. This state is non-abortable. wait_l2 = l2_read|l2_write.
  - An l2_write to the same block as pf_issue_q during PF_RD sets pf_stale.
  - On pmem_resp: buf_fill=1 unless pf_stale (or stale condition in the same cycle); pf_issued_cnt++ only when the fill happens; clear pf_stale; -> IDLE. A stalled L2 request is served from IDLE next cycle.
- Exactly one of pmem_read/pmem_write is high at a time. pmem strobes are held until pmem_resp.
- After every l2_resp the FSM spends at least one cycle in IDLE; L2 drops its request the cycle after l2_resp.
- Counters saturate at all-ones.

Test Plan:
- Reset mid-DEM_RD (pmem_read high) -> pmem_read=0 the same cycle; state IDLE; counters 0; a later pmem_resp is ignored.
- pf_req addr 0x1230, idle L2 -> PF_RD with pmem_address=0x1230; pmem_resp after 5 cycles -> buf_fill=1 for one cycle; pf_issued_cnt=1.
- L2 read 0x1234 with buf_hit=1 -> no pmem strobe; l2_resp exactly 2 cycles after request with buf_rdata value; pf_hit_cnt=1.
- L2 read 0x4000 asserted during PF_RD -> wait_l2=1 until prefetch resp, then DEM_RD to 0x4000, l2_resp with pmem_rdata; pmem_read never drops between the two transactions without a resp.
- L2 write 0x1238 during PF_RD to 0x1230 -> buf_fill stays 0 at prefetch resp; DEM_WR follows; pf_issued_cnt unchanged.
- Two pf_req pulses (0x2000, then 0x3000) while DEM_RD busy -> only 0x3000 is fetched; simultaneous demand read and pending prefetch in IDLE -> demand is issued first.
